// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if: stage register indices/control in, stall/flush/forward controls out
interface pipeline_hazard_controller_if;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       mem_read_e, pc_src_e, reg_write_m, mem_req_m, mem_ready_m, reg_write_w;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic [1:0] forward_a_e, forward_b_e;
  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output mem_read_e, pc_src_e, reg_write_m, mem_req_m, mem_ready_m, reg_write_w,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
    input  forward_a_e, forward_b_e
  );
  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  mem_read_e, pc_src_e, reg_write_m, mem_req_m, mem_ready_m, reg_write_w,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
    output forward_a_e, forward_b_e
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush/forward sequencing with memory-wait timeout and stall counter
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  pipeline_hazard_controller_if.slave  hz,
  output logic                         mem_err,
  output logic [CNT_W-1:0]             stall_cycles
);
  localparam int WW = $clog2(MEM_TIMEOUT) + 1;
  typedef enum logic [1:0] {RUN, WAIT, MEM_ERR} state_t;
  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          freeze, load_use;
  always_comb begin
    hz.forward_a_e = (hz.reg_write_m && hz.rd_m != 5'd0 && hz.rd_m == hz.rs1_e) ? 2'b10 :
                     (hz.reg_write_w && hz.rd_w != 5'd0 && hz.rd_w == hz.rs1_e) ? 2'b01 : 2'b00;
    hz.forward_b_e = (hz.reg_write_m && hz.rd_m != 5'd0 && hz.rd_m == hz.rs2_e) ? 2'b10 :
                     (hz.reg_write_w && hz.rd_w != 5'd0 && hz.rd_w == hz.rs2_e) ? 2'b01 : 2'b00;
  end
  // a taken branch squashes the dependent instruction, so it masks load-use
  always_comb begin
    freeze     = (hz.mem_req_m && !hz.mem_ready_m) || state == MEM_ERR;
    load_use   = hz.mem_read_e && hz.rd_e != 5'd0 && (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d);
    hz.stall_f = freeze || (!hz.pc_src_e && load_use);
    hz.stall_d = freeze || (!hz.pc_src_e && load_use);
    hz.stall_e = freeze;
    hz.stall_m = freeze;
    hz.flush_w = freeze;
    hz.flush_d = !freeze && hz.pc_src_e;
    hz.flush_e = !freeze && (hz.pc_src_e || load_use);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (hz.stall_f && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
      case (state)
        RUN: if (hz.mem_req_m && !hz.mem_ready_m) begin
          state    <= WAIT;
          wait_cnt <= WW'(1);
        end
        WAIT: if (hz.mem_ready_m) begin
          state    <= RUN;
          wait_cnt <= '0;
        end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
          state   <= MEM_ERR;
          mem_err <= 1'b1;
        end else wait_cnt <= wait_cnt + 1'b1;
        default: ;
      endcase
    end
  end
endmodule
